uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame (legal range 5..8).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port RX_IN, input, 1 bit: the serial line, idle high.
REQ-005 The block SHALL have port PAR_EN, input, 1 bit: 1 = the frame carries a parity bit.
REQ-006 The block SHALL have port Prescale, input, 6 bits: oversampling ratio; legal values are 8, 16 and 32.
REQ-007 The block SHALL have port strt_glitch, input, 1 bit: 1 = the start bit sampled high.
REQ-008 The block SHALL have port par_err, input, 1 bit: 1 = parity mismatch.
REQ-009 The block SHALL have port stp_err, input, 1 bit, using the stop-checker encoding: 1 = stop bit sampled high (no error), 0 = error; the value is held while stp_chk_en is low.
REQ-010 The block SHALL have port dat_samp_en, output, 1 bit: enables the bit sampler.
REQ-011 The block SHALL have ports strt_chk_en, deser_en, par_chk_en and stp_chk_en, each an output of 1 bit: one-cycle enables for the start, deserializer, parity and stop units.
REQ-012 The block SHALL have port edge_cnt, output, 6 bits: the oversample count within the current bit.
REQ-013 The block SHALL have port bit_cnt, output, 4 bits: the index of the data bit being received.
REQ-014 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse indicating a good frame.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and ERR_CHK.
REQ-016 The block SHALL latch Prescale on the IDLE->START transition; an illegal value SHALL be treated as 8 (P = latched value).
REQ-017 In IDLE with RX_IN==0, the block SHALL go to START, with edge_cnt=0 and bit_cnt=0 in the first START cycle.
REQ-018 In every non-IDLE state except ERR_CHK, edge_cnt SHALL increment by 1 per cycle, wrapping from P-1 to 0; the cycle with edge_cnt==P-1 is the "bit end".
REQ-019 The check point SHALL be edge_cnt == P/2+2; the sampled bit is valid from that cycle onward.
REQ-020 At the check point, the block SHALL pulse the enable for the current state: START->strt_chk_en, DATA->deser_en, PARITY->par_chk_en, STOP->stp_chk_en; each enable SHALL be high for exactly 1 cycle per bit.
REQ-021 START at bit end SHALL go to IDLE if strt_glitch==1 (no data_valid), else to DATA.
REQ-022 DATA at bit end with bit_cnt < DATA_WIDTH-1 SHALL increment bit_cnt and stay in DATA.
REQ-023 DATA at bit end with bit_cnt == DATA_WIDTH-1 SHALL go to PARITY if PAR_EN==1, else to STOP; bit_cnt SHALL then clear to 0.
REQ-024 PARITY SHALL capture par_err into an internal sticky flag at bit end and go to STOP; the flag SHALL clear on entry to START.
REQ-025 STOP at bit end SHALL go to ERR_CHK.
REQ-026 ERR_CHK SHALL last 1 cycle; data_valid SHALL be 1 in that cycle iff stp_err==1 and the parity flag==0.
REQ-027 ERR_CHK SHALL go to START if RX_IN==0 (back-to-back frames), else to IDLE.
REQ-028 dat_samp_en SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE and ERR_CHK.
REQ-029 RX_IN transitions outside IDLE/ERR_CHK SHALL NOT alter sequencing.
REQ-030 With P=8, DATA_WIDTH=8 and PAR_EN=0, frame latency SHALL be start detect to data_valid = 8+64+8+1 = 81 cycles.
REQ-031 PAR_EN changes mid-frame SHALL take effect only at the DATA->next decision.

Reset
REQ-032 When RST==1 at a clock edge, the FSM SHALL go to IDLE next cycle and edge_cnt, bit_cnt, all enables, data_valid and the parity flag SHALL be 0; this SHALL apply from any state, mid-frame included.
REQ-033 The first cycle after RST deasserts SHALL evaluate IDLE normally; a low RX_IN in that cycle SHALL start a frame.

Verification
REQ-034 The bench SHALL cover: P=8, PAR_EN=0, frame 0x55 with good stop -> deser_en pulses 8 times at edge_cnt==6, stp_chk_en once, data_valid=1 exactly 81 cycles after start detect.
REQ-035 The bench SHALL cover: P=16, PAR_EN=1, par_err=1 at parity bit end, stp_err=1 -> par_chk_en pulses once at edge_cnt==10; data_valid stays 0; FSM returns to IDLE.
REQ-036 The bench SHALL cover: P=8, start pulse of 2 cycles low, strt_glitch=1 -> IDLE after edge_cnt==7; no deser_en; data_valid=0.
REQ-037 The bench SHALL cover: stop bit low (stp_err=0) -> data_valid=0 in ERR_CHK; the next frame is received normally.
REQ-038 The bench SHALL cover: two back-to-back frames with RX_IN=0 in the ERR_CHK cycle -> direct ERR_CHK->START, edge_cnt=0 next cycle, and 2 data_valid pulses.
REQ-039 The bench SHALL cover: RST=1 during DATA with bit_cnt=4 -> next cycle IDLE with all outputs 0; a fresh frame after release yields data_valid=1.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer.
// Walks a serial frame (start, data, optional parity, stop) using an
// oversample counter, fires one-cycle enables at the mid-bit check point of
// each bit for the external start/deserializer/parity/stop units, and
// reports a good frame with a single-cycle data_valid in the ERR_CHK cycle.
//
// Output semantics: every enable and data_valid is a registered one-cycle
// pulse with no backpressure; a unit receiving an enable must act on it in
// that cycle. fsm_state exposes the current state (IDLE=0, START=1, DATA=2,
// PARITY=3, STOP=4, ERR_CHK=5) for observation only.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       data_valid,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } state_t;

  state_t     state;
  logic [5:0] p_reg;      // oversampling ratio frozen for the current frame
  logic       par_flag;   // sticky parity error for the current frame
  logic [5:0] p_legal;
  logic [5:0] chk_pre;
  logic [5:0] edge_next;
  logic       bit_end;
  logic       at_chk_pre;
  logic       last_bit;

  // Any unsupported oversampling ratio falls back to 8.
  always_comb begin
    p_legal = 6'd8;
    if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32) begin
      p_legal = Prescale;
    end
  end

  // The enables are registered, so they are raised one count before the
  // check point (P/2+2) and are therefore high exactly while edge_cnt
  // equals the check point. P/2+1 is always below P-1, so this never
  // collides with a bit end.
  assign bit_end    = (edge_cnt == p_reg - 6'd1);
  assign chk_pre    = (p_reg >> 1) + 6'd1;
  assign at_chk_pre = (edge_cnt == chk_pre);
  assign edge_next  = bit_end ? 6'd0 : edge_cnt + 6'd1;
  assign last_bit   = (bit_cnt == 4'(DATA_WIDTH - 1));
  assign fsm_state  = state;

  // Frame sequencer: state, counters and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      p_reg       <= 6'd8;
      par_flag    <= 1'b0;
      edge_cnt    <= 6'd0;
      bit_cnt     <= 4'd0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state       <= START;
            p_reg       <= p_legal;
            edge_cnt    <= 6'd0;
            bit_cnt     <= 4'd0;
            par_flag    <= 1'b0;
            dat_samp_en <= 1'b1;
          end
        end
        START: begin
          edge_cnt    <= edge_next;
          strt_chk_en <= at_chk_pre;
          if (bit_end) begin
            if (strt_glitch) begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          edge_cnt <= edge_next;
          deser_en <= at_chk_pre;
          if (bit_end) begin
            if (last_bit) begin
              bit_cnt <= 4'd0;
              state   <= PAR_EN ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          edge_cnt   <= edge_next;
          par_chk_en <= at_chk_pre;
          if (bit_end) begin
            par_flag <= par_flag | par_err;
            state    <= STOP;
          end
        end
        STOP: begin
          edge_cnt   <= edge_next;
          stp_chk_en <= at_chk_pre;
          if (bit_end) begin
            state       <= ERR_CHK;
            dat_samp_en <= 1'b0;
            data_valid  <= stp_err & ~par_flag;
          end
        end
        ERR_CHK: begin
          // A low line here is the start bit of a back-to-back frame.
          if (!RX_IN) begin
            state       <= START;
            edge_cnt    <= 6'd0;
            bit_cnt     <= 4'd0;
            par_flag    <= 1'b0;
            dat_samp_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          edge_cnt    <= 6'd0;
          bit_cnt     <= 4'd0;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frames are described by bit position and
// oversampling ratio; expected pulse times follow from frame arithmetic.
module tb_uart_rx_fsm;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       deser_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_valid;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  // Expected pulses: {kind[31:29], edge_cnt[28:23], bit_cnt[22:19], cycle[18:0]}
  // kind 0 strt_chk_en, 1 deser_en, 2 par_chk_en, 3 stp_chk_en, 4 data_valid
  logic [31:0] exp_q[$];
  int exp_dv  = 0;
  int seen_dv = 0;

  // Active windows (dat_samp_en high) of the previous and current frame.
  int w_lo[2];
  int w_hi[2];
  int w_p[2];

  // First cycle in which the FSM can sample a start (IDLE or ERR_CHK).
  int free_cyc    = 0;
  bit free_is_err = 1'b0;
  int last_p      = 8;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK         (clk),
    .RST         (rst),
    .RX_IN       (rx_in),
    .PAR_EN      (par_en),
    .Prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .data_valid  (data_valid),
    .fsm_state   (fsm_state)
  );

  // Clock and cycle counter (cycle n = interval after the n-th rising edge).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ev(input int kind, input int edge_v, input int bit_v, input int t);
    return {3'(kind), 6'(edge_v), 4'(bit_v), 19'(t)};
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({fsm_state, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                stp_chk_en, data_valid, edge_cnt, bit_cnt});
  endfunction

  // Monitor: pops an expectation for every pulse and checks the per-cycle
  // counters and sampler enable against the frame windows.
  always @(negedge clk) begin
    logic [4:0] pulses;
    int e_edge;
    int e_bit;
    int rel;
    int kb;
    bit e_samp;
    if (mon_on) begin
      pulses = {data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
      for (int k = 0; k < 5; k++) begin
        if (pulses[k]) begin
          if (k == 4) seen_dv++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse kind=%0d at cycle %0d: got pulse expected none", k, cyc);
          end else begin
            chk("pulse_event", mk_ev(k, int'(edge_cnt), int'(bit_cnt), cyc), exp_q.pop_front());
          end
        end
      end
      e_edge = 0;
      e_bit  = 0;
      e_samp = 1'b0;
      for (int w = 0; w < 2; w++) begin
        if (cyc >= w_lo[w] && cyc <= w_hi[w]) begin
          rel    = cyc - w_lo[w];
          kb     = rel / w_p[w];
          e_edge = rel % w_p[w];
          e_bit  = (kb >= 1 && kb <= DW) ? kb - 1 : 0;
          e_samp = 1'b1;
        end
      end
      chk("edge_cnt", 32'(edge_cnt), 32'(e_edge));
      chk("bit_cnt", 32'(bit_cnt), 32'(e_bit));
      chk("dat_samp_en", 32'(dat_samp_en), 32'(e_samp));
    end
  end

  // Driver + reference model for one frame. gap = idle-high cycles before
  // the start bit (0 or 1 right after a frame gives a back-to-back start);
  // rst_bit >= 0 asserts reset while bit_cnt equals that value.
  task automatic send_frame(input int p_in, input bit pe, input logic [7:0] data,
                            input bit glitch, input bit perr, input bit serr,
                            input int gap, input int rst_bit);
    int s;
    int p;
    int nb;
    int r;
    int chkp;
    bit b2b;
    logic [31:0] tail;
    if (gap > 0) begin
      rx_in = 1'b1;
      wait_cyc(cyc + gap);
    end
    if (cyc > free_cyc) chk("idle_before_frame", 32'(fsm_state), 32'd0);
    s    = ((cyc > free_cyc) ? cyc : free_cyc) + 1;
    b2b  = free_is_err && (s == free_cyc + 1);
    p    = b2b ? last_p : ((p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 8);
    nb   = glitch ? 1 : (DW + (pe ? 1 : 0) + 2);
    chkp = p / 2 + 2;
    prescale    = 6'(p_in);
    par_en      = pe;
    strt_glitch = glitch;
    par_err     = 1'b0;
    rx_in       = 1'b0;
    exp_q.push_back(mk_ev(0, chkp, 0, s + chkp));
    if (!glitch) begin
      for (int k = 1; k <= DW; k++) exp_q.push_back(mk_ev(1, chkp, k - 1, s + k * p + chkp));
      if (pe) exp_q.push_back(mk_ev(2, chkp, 0, s + (DW + 1) * p + chkp));
      exp_q.push_back(mk_ev(3, chkp, 0, s + (nb - 1) * p + chkp));
      if (serr && !(pe && perr)) begin
        exp_q.push_back(mk_ev(4, 0, 0, s + nb * p));
        exp_dv++;
      end
    end
    w_lo[0] = w_lo[1];
    w_hi[0] = w_hi[1];
    w_p[0]  = w_p[1];
    w_lo[1] = s;
    w_hi[1] = s + nb * p - 1;
    w_p[1]  = p;
    last_p      = p;
    free_cyc    = glitch ? s + p : s + nb * p;
    free_is_err = !glitch;
    if (glitch) begin
      wait_cyc(s + 1);
      rx_in = 1'b1;
      wait_cyc(s + p - 1);
      return;
    end
    for (int k = 1; k < nb; k++) begin
      wait_cyc(s - 1 + k * p);
      if (k <= DW) begin
        rx_in = data[k-1];
      end else if (pe && k == DW + 1) begin
        rx_in   = (^data) ^ perr;
        par_err = perr;
      end else begin
        rx_in   = serr;
        stp_err = serr;
      end
      // PAR_EN wanders during the data bits and settles on the last one.
      if (k < DW) par_en = 1'($urandom_range(0, 1));
      else if (k == DW) par_en = pe;
      if (rst_bit >= 0 && k == rst_bit + 1) begin
        r = s + k * p + int'($urandom_range(0, p - 2));
        wait_cyc(r);
        rst = 1'b1;
        while (exp_q.size() > 0) begin
          tail = exp_q[$];
          if (tail[18:0] < 19'(r + 1)) break;
          if (tail[31:29] == 3'd4) exp_dv--;
          void'(exp_q.pop_back());
        end
        w_hi[1] = r;
        wait_cyc(r + 1);
        chk("reset_mid_frame", out_vec(), 32'd0);
        rst         = 1'b0;
        rx_in       = 1'b1;
        free_cyc    = r + 1;
        free_is_err = 1'b0;
        return;
      end
    end
    wait_cyc(s - 1 + nb * p);
  endtask

  // Stimulus: directed frames, then randomized frames, then the report.
  initial begin
    int pv;
    int sel;
    rst         = 1'b1;
    rx_in       = 1'b1;
    par_en      = 1'b0;
    prescale    = 6'd8;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b1;
    for (int w = 0; w < 2; w++) begin
      w_lo[w] = 1;
      w_hi[w] = 0;
      w_p[w]  = 8;
    end
    wait_cyc(3);
    mon_on = 1'b1;
    chk("reset_state", out_vec(), 32'd0);
    rst = 1'b0;

    send_frame(8,  1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 3, -1);  // P=8 no parity, 81-cycle latency
    send_frame(16, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 3, -1);  // parity error
    send_frame(8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4, -1);  // start glitch
    send_frame(8,  1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 3, -1);  // stop error
    send_frame(16, 1'b1, 8'h96, 1'b0, 1'b0, 1'b1, 3, -1);  // good frame after it
    send_frame(16, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 0, -1);  // back-to-back
    send_frame(8,  1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 3, 4);   // reset at bit_cnt 4
    send_frame(8,  1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 0, -1);  // start in first cycle after reset
    send_frame(32, 1'b0, 8'hE7, 1'b0, 1'b0, 1'b1, 2, -1);  // P=32

    for (int i = 0; i < 14; i++) begin
      sel = int'($urandom_range(0, 9));
      pv  = (sel < 3) ? 8 : (sel < 6) ? 16 : (sel < 9) ? 32 : 12;
      send_frame(pv, 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0), int'($urandom_range(0, 4)), -1);
    end

    rx_in = 1'b1;
    wait_cyc(cyc + 20);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("data_valid_count", 32'(seen_dv), 32'(exp_dv));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit for the whole run.
  initial begin
    #2000000;
    total++;
    bad++;
    $display("FAIL watchdog: got time limit reached expected run complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
